// File: rtl/interrupt_request_controller_pkg.sv
// Shared interrupt definitions: FSM encoding, ISR-return register index, default mask.
// Constants only; no latency or backpressure of its own.
package interrupt_request_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   // The CPU control unit decodes jalr through this register as "return from ISR".
   localparam logic [4:0] ISR_RET_REG = 5'd30;

   // Wide enough for the largest supported source count; sliced to NUM_SRC at use.
   localparam logic [15:0] IRQ_MASK_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/interrupt_request_controller_prienc.sv
// Fixed-priority encoder, lowest index wins; purely combinational, zero latency.
// No flow control: the index is only meaningful while o_vld is high.
module irq_priority_encoder #(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 4
) (
   input  logic [NUM_SRC-1:0] req,
   output logic [ID_W-1:0]    idx,
   output logic               vld
);

   // Scanning from the top down lets the lowest set bit overwrite the rest.
   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = ID_W'(i);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/interrupt_request_controller.sv
// Edge-captures peripheral requests and issues one registered interrupt pulse per service.
// Pulse one cycle after the pending bit sets; further pulses held off until isr_return.
module interrupt_request_controller
   import interrupt_request_controller_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int ID_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_in,
   input  logic               mask_wr_en,
   input  logic [NUM_SRC-1:0] mask_wr_data,
   input  logic               isr_return,
   output logic               interupt_signanl,
   output logic [ID_W-1:0]    irq_id,
   output logic [NUM_SRC-1:0] irq_pending,
   output logic [NUM_SRC-1:0] irq_mask,
   output logic               in_service
);

   irq_state_t         r_state;
   irq_state_t         w_state_nxt;
   logic [NUM_SRC-1:0] r_prev;
   logic [NUM_SRC-1:0] r_pending;
   logic [NUM_SRC-1:0] r_mask;
   logic [ID_W-1:0]    r_irq_id;
   logic               r_int;

   logic [NUM_SRC-1:0] w_edge;
   logic [NUM_SRC-1:0] w_eligible;
   logic [NUM_SRC-1:0] w_clr;
   logic [NUM_SRC-1:0] w_pending_nxt;
   logic [ID_W-1:0]    w_sel_idx;
   logic               w_sel_vld;
   logic               w_grant;

   assign w_edge     = irq_in & ~r_prev;
   assign w_eligible = r_pending & r_mask;

   irq_priority_encoder #(
      .NUM_SRC (NUM_SRC),
      .ID_W    (ID_W)
   ) u_prienc (
      .req (w_eligible),
      .idx (w_sel_idx),
      .vld (w_sel_vld)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sel_vld) begin
               w_state_nxt = ST_ASSERT;
               w_grant     = 1'b1;
            end
         end
         ST_ASSERT:  w_state_nxt = ST_SERVICE;
         ST_SERVICE: if (isr_return) w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   // A fresh edge on the granted source survives the clear, so it is served again later.
   assign w_clr         = w_grant ? (NUM_SRC'(1) << w_sel_idx) : '0;
   assign w_pending_nxt = (r_pending & ~w_clr) | w_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_prev    <= '0;
         r_pending <= '0;
         r_mask    <= IRQ_MASK_DEFAULT[NUM_SRC-1:0];
         r_irq_id  <= '0;
         r_int     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_prev    <= irq_in;
         r_pending <= w_pending_nxt;
         r_int     <= w_grant;
         if (mask_wr_en) r_mask <= mask_wr_data;
         if (w_grant)    r_irq_id <= w_sel_idx;
      end
   end

   assign interupt_signanl = r_int;
   assign irq_id           = r_irq_id;
   assign irq_pending      = r_pending;
   assign irq_mask         = r_mask;
   assign in_service       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_interrupt_request_controller.sv
// Directed-vector bench for interrupt_request_controller (NUM_SRC=4, ID_W=4).
module tb_interrupt_request_controller;

   logic       clk;
   logic       reset;
   logic [3:0] irq_in;
   logic       mask_wr_en;
   logic [3:0] mask_wr_data;
   logic       isr_return;
   logic       interupt_signanl;
   logic [3:0] irq_id;
   logic [3:0] irq_pending;
   logic [3:0] irq_mask;
   logic       in_service;

   int checks   = 0;
   int failures = 0;

   interrupt_request_controller #(.NUM_SRC(4), .ID_W(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .irq_in           (irq_in),
      .mask_wr_en       (mask_wr_en),
      .mask_wr_data     (mask_wr_data),
      .isr_return       (isr_return),
      .interupt_signanl (interupt_signanl),
      .irq_id           (irq_id),
      .irq_pending      (irq_pending),
      .irq_mask         (irq_mask),
      .in_service       (in_service)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] irq;
      logic       mwe;
      logic [3:0] mdat;
      logic       ret;
      logic       e_int;
      logic [3:0] e_id;
      logic [3:0] e_pend;
      logic [3:0] e_mask;
      logic       e_svc;
   } vec_t;

   localparam int NV = 43;
   vec_t tbl [NV];

   function automatic logic [13:0] obs();
      return {interupt_signanl, irq_id, irq_pending, irq_mask, in_service};
   endfunction

   task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got int=%b id=%0d pend=%b mask=%b svc=%b, want int=%b id=%0d pend=%b mask=%b svc=%b",
                  name, act[13], act[12:9], act[8:5], act[4:1], act[0],
                  exp[13], exp[12:9], exp[8:5], exp[4:1], exp[0]);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, and leave outputs settled 1ns after the edge.
   task automatic step(input logic [3:0] irq, input logic mwe, input logic [3:0] md, input logic ret);
      irq_in       = irq;
      mask_wr_en   = mwe;
      mask_wr_data = md;
      isr_return   = ret;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;

      //          irq     mwe  mdat    ret  int id  pend     mask     svc
      tbl[0]  = '{4'b0000,1'b0,4'b0000,1'b0,1'b0,4'd0,4'b0000,4'b1111,1'b0};
      tbl[1]  = '{4'b0100,1'b0,4'b0000,1'b0,1'b0,4'd0,4'b0100,4'b1111,1'b0};
      tbl[2]  = '{4'b0100,1'b0,4'b0000,1'b0,1'b1,4'd2,4'b0000,4'b1111,1'b1};
      tbl[3]  = '{4'b0100,1'b0,4'b0000,1'b0,1'b0,4'd2,4'b0000,4'b1111,1'b1};
      tbl[4]  = '{4'b0000,1'b0,4'b0000,1'b1,1'b0,4'd2,4'b0000,4'b1111,1'b0};
      tbl[5]  = '{4'b0000,1'b0,4'b0000,1'b0,1'b0,4'd2,4'b0000,4'b1111,1'b0};
      tbl[6]  = '{4'b1010,1'b0,4'b0000,1'b0,1'b0,4'd2,4'b1010,4'b1111,1'b0};
      tbl[7]  = '{4'b1010,1'b0,4'b0000,1'b0,1'b1,4'd1,4'b1000,4'b1111,1'b1};
      tbl[8]  = '{4'b1010,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b1000,4'b1111,1'b1};
      tbl[9]  = '{4'b1010,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b1000,4'b1111,1'b1};
      tbl[10] = '{4'b1010,1'b0,4'b0000,1'b1,1'b0,4'd1,4'b1000,4'b1111,1'b0};
      tbl[11] = '{4'b1010,1'b0,4'b0000,1'b0,1'b1,4'd3,4'b0000,4'b1111,1'b1};
      tbl[12] = '{4'b1010,1'b0,4'b0000,1'b0,1'b0,4'd3,4'b0000,4'b1111,1'b1};
      tbl[13] = '{4'b1010,1'b0,4'b0000,1'b1,1'b0,4'd3,4'b0000,4'b1111,1'b0};
      tbl[14] = '{4'b0000,1'b0,4'b0000,1'b0,1'b0,4'd3,4'b0000,4'b1111,1'b0};
      tbl[15] = '{4'b0000,1'b1,4'b1110,1'b0,1'b0,4'd3,4'b0000,4'b1110,1'b0};
      tbl[16] = '{4'b0001,1'b0,4'b0000,1'b0,1'b0,4'd3,4'b0001,4'b1110,1'b0};
      tbl[17] = '{4'b0001,1'b0,4'b0000,1'b0,1'b0,4'd3,4'b0001,4'b1110,1'b0};
      tbl[18] = '{4'b0001,1'b1,4'b1111,1'b0,1'b0,4'd3,4'b0001,4'b1111,1'b0};
      tbl[19] = '{4'b0001,1'b0,4'b0000,1'b0,1'b1,4'd0,4'b0000,4'b1111,1'b1};
      tbl[20] = '{4'b0001,1'b0,4'b0000,1'b0,1'b0,4'd0,4'b0000,4'b1111,1'b1};
      tbl[21] = '{4'b0001,1'b0,4'b0000,1'b1,1'b0,4'd0,4'b0000,4'b1111,1'b0};
      tbl[22] = '{4'b0000,1'b0,4'b0000,1'b0,1'b0,4'd0,4'b0000,4'b1111,1'b0};
      tbl[23] = '{4'b0010,1'b0,4'b0000,1'b0,1'b0,4'd0,4'b0010,4'b1111,1'b0};
      tbl[24] = '{4'b0010,1'b0,4'b0000,1'b0,1'b1,4'd1,4'b0000,4'b1111,1'b1};
      tbl[25] = '{4'b0000,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b0000,4'b1111,1'b1};
      tbl[26] = '{4'b0010,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b0010,4'b1111,1'b1};
      tbl[27] = '{4'b0010,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b0010,4'b1111,1'b1};
      tbl[28] = '{4'b0010,1'b0,4'b0000,1'b1,1'b0,4'd1,4'b0010,4'b1111,1'b0};
      tbl[29] = '{4'b0010,1'b0,4'b0000,1'b0,1'b1,4'd1,4'b0000,4'b1111,1'b1};
      tbl[30] = '{4'b0010,1'b0,4'b0000,1'b1,1'b0,4'd1,4'b0000,4'b1111,1'b1};
      tbl[31] = '{4'b0010,1'b0,4'b0000,1'b1,1'b0,4'd1,4'b0000,4'b1111,1'b0};
      tbl[32] = '{4'b0000,1'b0,4'b0000,1'b1,1'b0,4'd1,4'b0000,4'b1111,1'b0};
      tbl[33] = '{4'b0000,1'b1,4'b1110,1'b0,1'b0,4'd1,4'b0000,4'b1110,1'b0};
      tbl[34] = '{4'b0001,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b0001,4'b1110,1'b0};
      tbl[35] = '{4'b0000,1'b0,4'b0000,1'b0,1'b0,4'd1,4'b0001,4'b1110,1'b0};
      tbl[36] = '{4'b0000,1'b1,4'b1111,1'b0,1'b0,4'd1,4'b0001,4'b1111,1'b0};
      tbl[37] = '{4'b0001,1'b0,4'b0000,1'b0,1'b1,4'd0,4'b0001,4'b1111,1'b1};
      tbl[38] = '{4'b0001,1'b0,4'b0000,1'b0,1'b0,4'd0,4'b0001,4'b1111,1'b1};
      tbl[39] = '{4'b0001,1'b0,4'b0000,1'b1,1'b0,4'd0,4'b0001,4'b1111,1'b0};
      tbl[40] = '{4'b0001,1'b0,4'b0000,1'b0,1'b1,4'd0,4'b0000,4'b1111,1'b1};
      tbl[41] = '{4'b0001,1'b0,4'b0000,1'b1,1'b0,4'd0,4'b0000,4'b1111,1'b1};
      tbl[42] = '{4'b0001,1'b0,4'b0000,1'b1,1'b0,4'd0,4'b0000,4'b1111,1'b0};

      reset        = 1'b1;
      irq_in       = 4'b0000;
      mask_wr_en   = 1'b0;
      mask_wr_data = 4'b0000;
      isr_return   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_values", obs(), {1'b0, 4'd0, 4'b0000, 4'b1111, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < NV; v++) begin
         step(tbl[v].irq, tbl[v].mwe, tbl[v].mdat, tbl[v].ret);
         chk($sformatf("vec%0d", v), obs(),
             {tbl[v].e_int, tbl[v].e_id, tbl[v].e_pend, tbl[v].e_mask, tbl[v].e_svc});
      end

      // Reset while in SERVICE with source 2 still pending.
      step(4'b0110, 1'b0, 4'b0000, 1'b0);
      step(4'b0110, 1'b0, 4'b0000, 1'b0);
      chk("rst_pre_grant", obs(), {1'b1, 4'd1, 4'b0100, 4'b1111, 1'b1});
      step(4'b0110, 1'b0, 4'b0000, 1'b0);
      chk("rst_pre_service", obs(), {1'b0, 4'd1, 4'b0100, 4'b1111, 1'b1});
      #2;
      reset  = 1'b1;
      irq_in = 4'b0000;
      #1;
      chk("rst_mid_service", obs(), {1'b0, 4'd0, 4'b0000, 4'b1111, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      pulses = 0;
      for (int c = 0; c < 20; c++) begin
         step(4'b0000, 1'b0, 4'b0000, 1'b0);
         if (interupt_signanl === 1'b1) pulses++;
      end
      chk_int("rst_no_pulse_20", pulses, 0);
      chk("rst_idle_after", obs(), {1'b0, 4'd0, 4'b0000, 4'b1111, 1'b0});

      // All sources masked: requests accumulate without any pulse.
      step(4'b1111, 1'b1, 4'b0000, 1'b0);
      pulses = 0;
      for (int c = 0; c < 8; c++) begin
         step(4'b1111, 1'b0, 4'b0000, 1'b0);
         if (interupt_signanl === 1'b1) pulses++;
      end
      chk_int("mask0_no_pulse", pulses, 0);
      chk("mask0_pending", obs(), {1'b0, 4'd0, 4'b1111, 4'b0000, 1'b0});
      step(4'b1111, 1'b1, 4'b1111, 1'b0);
      chk("unmask_write", obs(), {1'b0, 4'd0, 4'b1111, 4'b1111, 1'b0});
      step(4'b1111, 1'b0, 4'b0000, 1'b0);
      chk("unmask_grant0", obs(), {1'b1, 4'd0, 4'b1110, 4'b1111, 1'b1});

      // Serve the remaining three; pulses must never be back-to-back.
      pulses = 0;
      begin
         logic prev_int;
         int   b2b;
         prev_int = 1'b1;
         b2b = 0;
         for (int c = 0; c < 16; c++) begin
            step(4'b1111, 1'b0, 4'b0000, (c % 4) == 1);
            if (interupt_signanl === 1'b1) begin
               pulses++;
               if (prev_int === 1'b1) b2b++;
            end
            prev_int = interupt_signanl;
         end
         chk_int("drain_pulses", pulses, 3);
         chk_int("drain_back_to_back", b2b, 0);
      end
      chk("drain_final", obs(), {1'b0, 4'd3, 4'b0000, 4'b1111, 1'b0});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/interrupt_request_controller.md
Name: interrupt_request_controller

Overview:
- Initiator side of the CPU interrupt line: collects interrupt requests from peripherals (neuron accelerator, timers, I/O) and drives the single `interupt_signanl` input of the pipeline's interrupt control unit.
- Per source: rising-edge capture, pending latch and enable mask. Fixed priority selects the source to serve.
- Issues exactly one interrupt pulse per service, then holds off all further interrupts until the CPU signals return from the ISR (jalr through x30).

Parameters:
- NUM_SRC, 4: number of peripheral request lines (1..16).
- ID_W, 4: width of `irq_id`; must satisfy 2**ID_W >= NUM_SRC.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- irq_in  input  NUM_SRC  level request lines from peripherals; rising edge = new request.
- mask_wr_en  input  1  write strobe for the enable mask.
- mask_wr_data  input  NUM_SRC  new enable mask; bit i = 1 enables source i.
- isr_return  input  1  high for one cycle when the CPU executes jalr with rs1 = x30.
- interupt_signanl  output  1  registered one-cycle interrupt pulse to the CPU interrupt control unit.
- irq_id  output  ID_W  index of the source being or last served; the ISR reads it.
- irq_pending  output  NUM_SRC  current pending register, for status readback.
- irq_mask  output  NUM_SRC  current enable mask.
- in_service  output  1  high from the pulse until ISR return.

Behaviour:
- Reset (async, active-high):
  - state = IDLE.
  - `interupt_signanl` = 0, `irq_id` = 0, `irq_pending` = 0, `irq_mask` = all 1s, `in_service` = 0.
  - Edge-detect history register = 0.
- Edge capture:
  - `irq_prev` register; edge[i] = irq_in[i] & ~irq_prev[i].
  - Each posedge: pending |= edge. Levels held high produce no further requests.
- Mask:
  - On `mask_wr_en`, the mask updates at posedge.
  - The state machine uses the pre-write mask in that same cycle.
  - A masked source stays pending and is served once unmasked.
- Selection:
  - eligible = pending & mask. The lowest index has highest priority.
- FSM states and transitions:
  - IDLE: if eligible != 0 → ASSERT. At that posedge:
    - latch `irq_id` = selected index;
    - clear that pending bit;
    - set `interupt_signanl` = 1.
  - ASSERT (exactly 1 cycle): `interupt_signanl` = 1, `in_service` = 1 → SERVICE. At the posedge leaving ASSERT, `interupt_signanl` returns to 0.
  - SERVICE: `in_service` = 1; `interupt_signanl` = 0. If `isr_return` = 1 → IDLE, `in_service` = 0 next cycle.
- Latency:
  - Edge sampled at posedge k sets pending.
  - The pulse is high from posedge k+1 to k+2. The CPU samples it at the negedge inside that window.
- Boundary conditions:
  - Simultaneous edges on several sources: all pend; served one at a time in index order, each needing its own `isr_return`.
  - New edge on the source currently in service: it re-pends, because its pending bit was cleared at grant. It is served again after return.
  - Edge arriving in the same cycle its pending bit is cleared by grant: the set wins, so pending stays 1.
  - `isr_return` in IDLE or ASSERT: ignored.
  - `isr_return` and a new eligible request in the same cycle in SERVICE: go to IDLE first. The next pulse comes no earlier than 1 cycle later. Pulses are never back-to-back.
  - Mask all 0s: no pulses; pending keeps accumulating.
  - Reset mid-SERVICE or mid-ASSERT: immediate return to reset values; pending requests are lost.

Decomposition:
- Shared interrupt package holds:
  - FSM state encoding: IDLE = 0, ASSERT = 1, SERVICE = 2.
  - ISR return register index: 5'd30, the same constant the CPU control unit uses.
  - Default mask value.
- One natural sub-module: `irq_priority_encoder`. Combinational, NUM_SRC-wide, lowest-index-first; outputs index and valid.

Test Plan:
- Reset: assert reset mid-cycle → all outputs at reset values immediately, mask = 4'b1111, no pulse.
- Single request: irq_in[2] rises before posedge k → `interupt_signanl` high for exactly cycle k+1 to k+2, `irq_id` = 2, `irq_pending` = 0, `in_service` = 1; pulse `isr_return` → `in_service` = 0.
- Simultaneous request: irq_in = 4'b1010 rises together → first pulse with `irq_id` = 1 and pending = 4'b1000. After `isr_return`, second pulse with `irq_id` = 3. Exactly two pulses total.
- Mask: write mask 4'b1110, then irq_in[0] rises → no pulse, pending = 4'b0001. Write mask 4'b1111 → pulse with `irq_id` = 0.
- Re-trigger: during SERVICE of source 1, toggle irq_in[1] low then high → pending[1] = 1, no pulse until `isr_return`. Then a second pulse with `irq_id` = 1.
- Reset during service: reset in SERVICE with pending = 4'b0100 → state IDLE, pending = 0. After reset release with no new edges, no pulse for 20 cycles.
